// File: rtl/cam_capture.sv
// cam_capture: OV7670 8-bit parallel bus capture front end.
//
// Follows VSYNC/HREF framing, pairs RGB565 bytes (high byte first) into
// 16-bit pixels and emits each accepted pixel with a one-cycle valid strobe
// and its linear frame-buffer address (line*H_PIXELS + column).
//
// Ports:
//   p_clock      camera pixel clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   vsync        frame sync, high = vertical blanking
//   href         line valid, high = cam_data carries a byte
//   cam_data     camera data byte
//   pixel_data   assembled pixel {first byte, second byte}
//   pixel_valid  one-cycle strobe for pixel_data / pixel_addr
//   pixel_addr   linear address of the strobed pixel
//   frame_done   one-cycle strobe when a captured frame ends
//   capturing    high while inside a frame (LINE_HI / LINE_LO)
module cam_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 120,
  parameter int ADDR_W   = 15
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_data,
  output logic [15:0]       pixel_data,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              frame_done,
  output logic              capturing
);

  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);

  localparam logic [COL_W-1:0]  H_MAX  = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] V_MAX  = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    WAIT_VS    = 2'd0,
    WAIT_START = 2'd1,
    LINE_HI    = 2'd2,
    LINE_LO    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  // Address of column 0 of the current line; adding the column gives the
  // pixel address without a multiplier.
  logic [ADDR_W-1:0]   line_base_q, line_base_d;
  logic                href_prev_q, href_prev_d;
  logic [15:0]         pixel_data_q, pixel_data_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [ADDR_W-1:0]   pixel_addr_q, pixel_addr_d;
  logic                frame_done_q, frame_done_d;
  logic                capturing_q, capturing_d;

  logic in_line;
  logic eol;
  logic form;
  logic accept;

  // vsync has priority over href everywhere inside a frame.
  assign in_line = (state_q == LINE_HI) || (state_q == LINE_LO);
  assign eol     = in_line && !vsync && !href && href_prev_q;
  assign form    = (state_q == LINE_LO) && !vsync && href;
  assign accept  = form && (col_q < H_MAX) && (line_q < V_MAX);

  // State register and datapath registers
  always_ff @(posedge p_clock) begin
    if (rst) begin
      state_q       <= WAIT_VS;
      hi_q          <= '0;
      col_q         <= '0;
      line_q        <= '0;
      line_base_q   <= '0;
      href_prev_q   <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_addr_q  <= '0;
      frame_done_q  <= 1'b0;
      capturing_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      col_q         <= col_d;
      line_q        <= line_d;
      line_base_q   <= line_base_d;
      href_prev_q   <= href_prev_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_addr_q  <= pixel_addr_d;
      frame_done_q  <= frame_done_d;
      capturing_q   <= capturing_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_VS: begin
        // Never start mid-frame: require a blanking interval first.
        if (vsync) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!vsync) state_d = LINE_HI;
      end
      LINE_HI: begin
        if (vsync)     state_d = WAIT_START;
        else if (href) state_d = LINE_LO;
      end
      LINE_LO: begin
        // href low here is always a line end (we arrived with href high);
        // the orphan high byte is dropped by simply returning to LINE_HI.
        if (vsync)                    state_d = WAIT_START;
        else if (href || href_prev_q) state_d = LINE_HI;
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    hi_d          = hi_q;
    col_d         = col_q;
    line_d        = line_q;
    line_base_d   = line_base_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pixel_addr_d  = pixel_addr_q;
    frame_done_d  = 1'b0;
    href_prev_d   = in_line && !vsync && href;
    capturing_d   = (state_d == LINE_HI) || (state_d == LINE_LO);

    if ((state_q == WAIT_START) && !vsync) begin
      col_d        = '0;
      line_d       = '0;
      line_base_d  = '0;
      pixel_addr_d = '0;
    end

    if ((state_q == LINE_HI) && !vsync && href) begin
      hi_d = cam_data;
    end

    if (form) begin
      if (accept) begin
        pixel_data_d  = {hi_q, cam_data};
        pixel_valid_d = 1'b1;
        pixel_addr_d  = line_base_q + ADDR_W'(col_q);
      end
      // Saturating column count keeps overlong lines from wrapping back
      // into the accepted range.
      if (col_q != H_MAX) col_d = col_q + COL_W'(1);
    end

    if (eol) begin
      col_d = '0;
      if (line_q != V_MAX) begin
        line_d      = line_q + LINE_W'(1);
        line_base_d = line_base_q + H_STEP;
      end
    end

    if (in_line && vsync) begin
      frame_done_d = 1'b1;
      hi_d         = '0;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_addr  = pixel_addr_q;
  assign frame_done  = frame_done_q;
  assign capturing   = capturing_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed testbench for cam_capture with H_PIXELS=4, V_LINES=2.
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 15;

  logic          p_clock = 1'b0;
  logic          rst = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [15:0]   pixel_data;
  logic          pixel_valid;
  logic [AW-1:0] pixel_addr;
  logic          frame_done;
  logic          capturing;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]   q_data[$];
  logic [AW-1:0] q_addr[$];
  int            fd_count = 0;

  cam_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .p_clock    (p_clock),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_addr (pixel_addr),
    .frame_done (frame_done),
    .capturing  (capturing)
  );

  always #5 p_clock = ~p_clock;

  // Record strobes on the falling edge, away from the active edge.
  always @(negedge p_clock) begin
    if (pixel_valid) begin
      q_data.push_back(pixel_data);
      q_addr.push_back(pixel_addr);
      $display("pixel data=%h addr=%0d t=%0t", pixel_data, pixel_addr, $time);
    end
    if (frame_done) begin
      fd_count++;
      $display("frame_done t=%0t", $time);
    end
  end

  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    vsync = vs;
    href = hr;
    cam_data = d;
    @(posedge p_clock);
    #1;
  endtask

  task automatic clear_mon();
    q_data.delete();
    q_addr.delete();
    fd_count = 0;
  endtask

  task automatic start_frame();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
  endtask

  // n pixels {hi+k*inc, lo+k*inc}, followed by one href-low cycle.
  task automatic send_pixels(input int n, input logic [7:0] hi, input logic [7:0] lo, input int inc);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, hi + 8'(k * inc));
      step(1'b0, 1'b1, lo + 8'(k * inc));
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    n_cmp++; if (pixel_data !== 16'h0000) begin n_bad++; $display("FAIL reset_pixel_data got=%h exp=0000", pixel_data); end
    n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_pixel_valid got=%b exp=0", pixel_valid); end
    n_cmp++; if (pixel_addr !== '0) begin n_bad++; $display("FAIL reset_pixel_addr got=%0d exp=0", pixel_addr); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    n_cmp++; if (capturing !== 1'b0) begin n_bad++; $display("FAIL reset_capturing got=%b exp=0", capturing); end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    clear_mon();
    start_frame();
    n_cmp++; if (capturing !== 1'b1) begin n_bad++; $display("FAIL t1_capturing_on got=%b exp=1", capturing); end
    send_pixels(4, 8'hF8, 8'h00, 0);
    send_pixels(4, 8'hF8, 8'h00, 0);
    end_frame();
    n_cmp++; if (q_data.size() !== 8) begin n_bad++; $display("FAIL t1_count got=%0d exp=8", q_data.size()); end
    for (int i = 0; i < 8 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== 16'hF800) begin n_bad++; $display("FAIL t1_data[%0d] got=%h exp=f800", i, q_data[i]); end
      n_cmp++; if (q_addr[i] !== AW'(i)) begin n_bad++; $display("FAIL t1_addr[%0d] got=%0d exp=%0d", i, q_addr[i], i); end
    end
    n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL t1_frame_done got=%0d exp=1", fd_count); end
    n_cmp++; if (capturing !== 1'b0) begin n_bad++; $display("FAIL t1_capturing_off got=%b exp=0", capturing); end
  endtask

  task automatic test_odd_bytes();
    logic [15:0]   ed [3] = '{16'h1234, 16'h5678, 16'hAABB};
    logic [AW-1:0] ea [3] = '{15'd0, 15'd1, 15'd4};
    clear_mon();
    start_frame();
    step(1'b0, 1'b1, 8'h12);
    step(1'b0, 1'b1, 8'h34);
    step(1'b0, 1'b1, 8'h56);
    step(1'b0, 1'b1, 8'h78);
    step(1'b0, 1'b1, 8'h9A);
    step(1'b0, 1'b0, 8'h00);
    send_pixels(1, 8'hAA, 8'hBB, 0);
    end_frame();
    n_cmp++; if (q_data.size() !== 3) begin n_bad++; $display("FAIL t2_count got=%0d exp=3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== ed[i]) begin n_bad++; $display("FAIL t2_data[%0d] got=%h exp=%h", i, q_data[i], ed[i]); end
      n_cmp++; if (q_addr[i] !== ea[i]) begin n_bad++; $display("FAIL t2_addr[%0d] got=%0d exp=%0d", i, q_addr[i], ea[i]); end
    end
    n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL t2_frame_done got=%0d exp=1", fd_count); end
  endtask

  task automatic test_long_line();
    logic [15:0]   ed [5] = '{16'h1020, 16'h1121, 16'h1222, 16'h1323, 16'h7788};
    logic [AW-1:0] ea [5] = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4};
    clear_mon();
    start_frame();
    send_pixels(6, 8'h10, 8'h20, 1);
    send_pixels(1, 8'h77, 8'h88, 0);
    end_frame();
    n_cmp++; if (q_data.size() !== 5) begin n_bad++; $display("FAIL t3_count got=%0d exp=5", q_data.size()); end
    for (int i = 0; i < 5 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== ed[i]) begin n_bad++; $display("FAIL t3_data[%0d] got=%h exp=%h", i, q_data[i], ed[i]); end
      n_cmp++; if (q_addr[i] !== ea[i]) begin n_bad++; $display("FAIL t3_addr[%0d] got=%0d exp=%0d", i, q_addr[i], ea[i]); end
    end
  endtask

  task automatic test_extra_lines();
    logic [15:0]   ed [4] = '{16'hA00A, 16'hA10B, 16'hB00B, 16'hB10C};
    logic [AW-1:0] ea [4] = '{15'd0, 15'd1, 15'd4, 15'd5};
    clear_mon();
    start_frame();
    send_pixels(2, 8'hA0, 8'h0A, 1);
    send_pixels(2, 8'hB0, 8'h0B, 1);
    send_pixels(2, 8'hC0, 8'h0C, 1);
    end_frame();
    n_cmp++; if (q_data.size() !== 4) begin n_bad++; $display("FAIL t4_count got=%0d exp=4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== ed[i]) begin n_bad++; $display("FAIL t4_data[%0d] got=%h exp=%h", i, q_data[i], ed[i]); end
      n_cmp++; if (q_addr[i] !== ea[i]) begin n_bad++; $display("FAIL t4_addr[%0d] got=%0d exp=%0d", i, q_addr[i], ea[i]); end
    end
    n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL t4_frame_done got=%0d exp=1", fd_count); end
  endtask

  task automatic test_wait_vsync();
    test_reset();
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h50 + 8'(i));
      n_cmp++; if (capturing !== 1'b0) begin n_bad++; $display("FAIL t5_capturing_pre[%0d] got=%b exp=0", i, capturing); end
    end
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    n_cmp++; if (capturing !== 1'b0) begin n_bad++; $display("FAIL t5_capturing_vs got=%b exp=0", capturing); end
    n_cmp++; if (q_data.size() !== 0) begin n_bad++; $display("FAIL t5_pre_count got=%0d exp=0", q_data.size()); end
    step(1'b0, 1'b0, 8'h00);
    n_cmp++; if (capturing !== 1'b1) begin n_bad++; $display("FAIL t5_capturing_on got=%b exp=1", capturing); end
    send_pixels(1, 8'hC3, 8'h5A, 0);
    end_frame();
    n_cmp++; if (q_data.size() !== 1) begin n_bad++; $display("FAIL t5_count got=%0d exp=1", q_data.size()); end
    if (q_data.size() > 0) begin
      n_cmp++; if (q_data[0] !== 16'hC35A) begin n_bad++; $display("FAIL t5_data got=%h exp=c35a", q_data[0]); end
      n_cmp++; if (q_addr[0] !== 15'd0) begin n_bad++; $display("FAIL t5_addr got=%0d exp=0", q_addr[0]); end
    end
  endtask

  task automatic test_mid_reset();
    clear_mon();
    start_frame();
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'hAB);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'hCD);
    rst = 1'b0;
    n_cmp++; if (pixel_data !== 16'h0000) begin n_bad++; $display("FAIL t6_pixel_data got=%h exp=0000", pixel_data); end
    n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL t6_pixel_valid got=%b exp=0", pixel_valid); end
    n_cmp++; if (pixel_addr !== '0) begin n_bad++; $display("FAIL t6_pixel_addr got=%0d exp=0", pixel_addr); end
    n_cmp++; if (capturing !== 1'b0) begin n_bad++; $display("FAIL t6_capturing got=%b exp=0", capturing); end
    n_cmp++; if (q_data.size() !== 1) begin n_bad++; $display("FAIL t6_pre_count got=%0d exp=1", q_data.size()); end
    clear_mon();
    // Bytes with vsync low right after reset must not be captured.
    send_pixels(2, 8'h01, 8'h02, 1);
    start_frame();
    send_pixels(2, 8'h40, 8'h80, 1);
    end_frame();
    n_cmp++; if (q_data.size() !== 2) begin n_bad++; $display("FAIL t6_count got=%0d exp=2", q_data.size()); end
    if (q_data.size() >= 2) begin
      n_cmp++; if (q_data[0] !== 16'h4080) begin n_bad++; $display("FAIL t6_data0 got=%h exp=4080", q_data[0]); end
      n_cmp++; if (q_addr[0] !== 15'd0) begin n_bad++; $display("FAIL t6_addr0 got=%0d exp=0", q_addr[0]); end
      n_cmp++; if (q_data[1] !== 16'h4181) begin n_bad++; $display("FAIL t6_data1 got=%h exp=4181", q_data[1]); end
      n_cmp++; if (q_addr[1] !== 15'd1) begin n_bad++; $display("FAIL t6_addr1 got=%0d exp=1", q_addr[1]); end
    end
    n_cmp++; if (fd_count !== 1) begin n_bad++; $display("FAIL t6_frame_done got=%0d exp=1", fd_count); end
  endtask

  initial begin
    #2;
    test_reset();
    test_full_frame();
    test_odd_bytes();
    test_long_line();
    test_extra_lines();
    test_wait_vsync();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
Upstream stage of the colour classifier.
- Samples the OV7670 8-bit parallel bus (VSYNC/HREF framed, RGB565 sent high byte first).
- Pairs consecutive bytes into 16-bit pixels and presents each with a one-cycle valid strobe and a linear frame-buffer address.
- Its `pixel_data` output feeds the colour classifier's `pixel_data` input and the frame buffer write port.

Parameters:
- H_PIXELS, 160, accepted pixels per line; pixels beyond this count in a line are dropped.
- V_LINES, 120, accepted lines per frame; lines beyond this count are dropped.
- ADDR_W, 15, width of `pixel_addr`; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- p_clock  in  1  camera pixel clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- vsync  in  1  camera frame sync; high = vertical blanking.
- href  in  1  camera line valid; high = bytes on `cam_data` are valid.
- cam_data  in  8  camera data byte.
- pixel_data  out  16  assembled RGB565 pixel as {first byte, second byte}.
- pixel_valid  out  1  one-cycle strobe: `pixel_data` and `pixel_addr` are valid.
- pixel_addr  out  ADDR_W  linear address of the current pixel: line*H_PIXELS + column.
- frame_done  out  1  one-cycle strobe at the end of a captured frame.
- capturing  out  1  high while in LINE_HI or LINE_LO.

Behaviour:
- Interface: one clock, `p_clock`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `p_clock`.
- All outputs are registered.

Reset state:
- state=WAIT_VS.
- `pixel_data`=0, `pixel_valid`=0, `pixel_addr`=0, `frame_done`=0, `capturing`=0.
- Column counter, line counter and high-byte register all =0.

FSM states:
- WAIT_VS: wait for `vsync`=1, then go to WAIT_START. Guarantees capture begins only on a whole frame.
- WAIT_START: wait for `vsync`=0. On that cycle, clear column, line and address counters and go to LINE_HI.
- LINE_HI: if `href`=1, latch `cam_data` into the high-byte register and go to LINE_LO. If `href`=0, stay.
- LINE_LO: if `href`=1, form a pixel from {high byte, `cam_data`} and return to LINE_HI.

Pixel acceptance and output timing:
- A formed pixel is accepted only if column < H_PIXELS and line < V_LINES.
- Accepted pixel: on the next edge, `pixel_data`={hi, byte}, `pixel_valid`=1, `pixel_addr`=current address. The address then increments. Latency is 1 cycle after the second byte is sampled.
- Non-accepted pixel: `pixel_valid` stays 0 and the address does not change.
- The column counter increments on every formed pixel and saturates at H_PIXELS.
- `pixel_valid` is high for one cycle only. `pixel_data` and `pixel_addr` hold their values between strobes.

End of line (falling `href`, i.e. `href`=0 in LINE_HI or LINE_LO when the previous `href`=1):
- Increment the line counter (saturating at V_LINES) and clear the column counter.
- If this happens in LINE_LO, the orphan high byte is discarded: no pixel is emitted and the FSM returns to LINE_HI.

End of frame:
- `vsync`=1 in LINE_HI or LINE_LO: pulse `frame_done` for one cycle, drop any partial byte and go to WAIT_START.
- `pixel_addr` is not cleared until the next frame start.

Other rules:
- `href` and `vsync` asserted on the same cycle: `vsync` wins. The byte is ignored and end-of-frame handling applies.
- `rst` mid-frame: return to reset state. Capture resumes only after a full `vsync` high-then-low sequence; no `frame_done` is emitted for the aborted frame.
- Address arithmetic is unsigned ADDR_W and never wraps within a frame, because the H/V limits bound it.
- `capturing`=1 exactly in LINE_HI and LINE_LO.

Test Plan:
1. Reset, frame of 2 lines × 4 pixels (H_PIXELS=4, V_LINES=2), bytes 0xF8,0x00 repeated -> 8 `pixel_valid` strobes, `pixel_data`=16'hF800, `pixel_addr` 0..7, then one `frame_done` on `vsync` rise.
2. `href` high for 5 bytes (0x12,0x34,0x56,0x78,0x9A) -> two pixels 16'h1234 (addr 0) and 16'h5678 (addr 1); 0x9A discarded; next line starts at addr 4 (line 1, column 0).
3. Line of 6 pixels with H_PIXELS=4 -> only first 4 strobed (addr 0..3); the 5th and 6th produce no `pixel_valid`; next line starts at addr 4.
4. Frame with 3 lines with V_LINES=2 -> no strobes during line 3; `frame_done` still pulses once on `vsync`.
5. Bytes arrive with `vsync` low before the first `vsync` high after reset -> no `pixel_valid`, `capturing`=0; capture starts only after `vsync` goes 1 then 0.
6. Assert `rst` mid-line after the high byte 0xAB -> all outputs 0 next cycle, no strobe and no `frame_done`; the next full frame is captured starting at addr 0.
